// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Bridges a single-outstanding command/response interface onto an AXI4-Lite
//   master port. One transaction is in flight at a time. The response, with
//   its AXI resp code, is held until the user consumes it. A saturating counter
//   tracks non-OKAY responses.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_cmd_* / o_cmd_ready    command channel (valid/ready)
//   o_rsp_* / i_rsp_ready    response channel (valid/ready)
//   o_err_count              saturating count of non-OKAY responses
//   o_aw*/o_w*/o_b*/o_ar*/o_r* and matching i_*   AXI4-Lite master port
module axi_lite_master #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    // command channel
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]    i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]    i_cmd_wdata,
    input  logic [STROBE_WIDTH-1:0]  i_cmd_wstrb,
    // response channel
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_write,
    output logic [DATA_WIDTH-1:0]    o_rsp_rdata,
    output logic [1:0]               o_rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count,
    // AXI write address
    output logic                     o_awvalid,
    output logic [ADDR_WIDTH-1:0]    o_awaddr,
    input  logic                     i_awready,
    // AXI write data
    output logic                     o_wvalid,
    output logic [DATA_WIDTH-1:0]    o_wdata,
    output logic [STROBE_WIDTH-1:0]  o_wstrb,
    input  logic                     i_wready,
    // AXI write response
    input  logic                     i_bvalid,
    output logic                     o_bready,
    input  logic [1:0]               i_bresp,
    // AXI read address
    output logic                     o_arvalid,
    output logic [ADDR_WIDTH-1:0]    o_araddr,
    input  logic                     i_arready,
    // AXI read data
    input  logic                     i_rvalid,
    output logic                     o_rready,
    input  logic [DATA_WIDTH-1:0]    i_rdata,
    input  logic [1:0]               i_rresp
);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp
    } state_e;

    state_e                   state_q, state_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     arvalid_q, arvalid_d;
    logic                     bready_q, bready_d;
    logic                     rready_q, rready_d;
    logic                     aw_done_q, aw_done_d;
    logic                     w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STROBE_WIDTH-1:0]  wstrb_q, wstrb_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]               rsp_resp_q, rsp_resp_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic aw_fire, w_fire, aw_done_now, w_done_now;
    logic rsp_capture;
    logic [1:0] captured_resp;

    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_capture   = 1'b0;
        captured_resp = 2'b00;

        aw_fire     = awvalid_q & i_awready;
        w_fire      = wvalid_q & i_wready;
        aw_done_now = aw_done_q | aw_fire;
        w_done_now  = w_done_q | w_fire;

        case (state_q)
            StIdle: begin
                if (i_cmd_valid) begin
                    addr_d    = i_cmd_addr;
                    wdata_d   = i_cmd_wdata;
                    wstrb_d   = i_cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (i_cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrReq;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRdReq;
                    end
                end
            end
            StWrReq: begin
                // AW and W retire independently; B is only solicited once both are done.
                if (aw_fire) awvalid_d = 1'b0;
                if (w_fire)  wvalid_d  = 1'b0;
                aw_done_d = aw_done_now;
                w_done_d  = w_done_now;
                if (aw_done_now && w_done_now) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = StWrResp;
                end
            end
            StWrResp: begin
                if (i_bvalid && bready_q) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = i_bresp;
                    rsp_capture   = 1'b1;
                    captured_resp = i_bresp;
                    state_d       = StRsp;
                end
            end
            StRdReq: begin
                if (i_arready && arvalid_q) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdResp;
                end
            end
            StRdResp: begin
                if (i_rvalid && rready_q) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_write_d   = 1'b0;
                    rsp_rdata_d   = i_rdata;
                    rsp_resp_d    = i_rresp;
                    rsp_capture   = 1'b1;
                    captured_resp = i_rresp;
                    state_d       = StRsp;
                end
            end
            StRsp: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_count_d = err_count_q;
        if (rsp_capture && (captured_resp != 2'b00) && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            err_count_q <= err_count_d;
        end
    end

    assign o_cmd_ready = (state_q == StIdle);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_write = rsp_write_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_err_count = err_count_q;
    assign o_awvalid   = awvalid_q;
    assign o_awaddr    = addr_q;
    assign o_wvalid    = wvalid_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_bready    = bready_q;
    assign o_arvalid   = arvalid_q;
    assign o_araddr    = addr_q;
    assign o_rready    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
//   Randomized self-checking bench. A behavioural AXI-Lite slave with a small
//   word memory and programmable wait states answers the DUT; a reference
//   memory plus error tally predicts every response.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_write = 1'b0;
    logic [31:0] i_cmd_addr = '0;
    logic [31:0] i_cmd_wdata = '0;
    logic [3:0]  i_cmd_wstrb = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic        o_rsp_write;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic [7:0]  o_err_count;
    logic        o_awvalid;
    logic [31:0] o_awaddr;
    logic        i_awready = 1'b0;
    logic        o_wvalid;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_wready = 1'b0;
    logic        i_bvalid = 1'b0;
    logic        o_bready;
    logic [1:0]  i_bresp = 2'b00;
    logic        o_arvalid;
    logic [31:0] o_araddr;
    logic        i_arready = 1'b0;
    logic        i_rvalid = 1'b0;
    logic        o_rready;
    logic [31:0] i_rdata = '0;
    logic [1:0]  i_rresp = 2'b00;

    axi_lite_master dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_err_count(o_err_count),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Slave configuration, set by the stimulus before each command.
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] b_resp_sel = 2'b00, r_resp_sel = 2'b00;

    // ---------------- behavioural AXI-Lite slave + protocol observer ----------------
    logic [31:0] slv_mem [16] = '{default: 32'h0};
    bit          aw_arm, w_arm, b_arm, ar_arm, r_arm;
    bit          have_aw, have_w, have_ar;
    bit          prev_awvalid, prev_wvalid, prev_arvalid, prev_bready, prev_rready;
    logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
    logic [3:0]  prev_wstrb;
    logic [31:0] aw_cap, w_cap, ar_cap;
    logic [3:0]  ws_cap;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

    always @(negedge clk) begin
        if (rst) begin
            i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0;
            aw_arm = 0; w_arm = 0; b_arm = 0; ar_arm = 0; r_arm = 0;
            have_aw = 0; have_w = 0; have_ar = 0;
            prev_awvalid = 0; prev_wvalid = 0; prev_arvalid = 0; prev_bready = 0;
            prev_rready = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            // Handshakes armed at the previous negedge completed at the posedge between.
            if (aw_arm) begin
                check_eq("awvalid_drop", 32'(o_awvalid), 0);
                i_awready = 0; have_aw = 1; aw_cnt = 0;
            end else if (prev_awvalid) begin
                check_eq("awvalid_held", 32'(o_awvalid), 1);
                check_eq("awaddr_stable", o_awaddr, prev_awaddr);
            end
            if (w_arm) begin
                check_eq("wvalid_drop", 32'(o_wvalid), 0);
                i_wready = 0; have_w = 1; w_cnt = 0;
            end else if (prev_wvalid) begin
                check_eq("wvalid_held", 32'(o_wvalid), 1);
                check_eq("wdata_stable", o_wdata, prev_wdata);
                check_eq("wstrb_stable", 32'(o_wstrb), 32'(prev_wstrb));
            end
            if (ar_arm) begin
                check_eq("arvalid_drop", 32'(o_arvalid), 0);
                i_arready = 0; have_ar = 1; ar_cnt = 0;
            end else if (prev_arvalid) begin
                check_eq("arvalid_held", 32'(o_arvalid), 1);
                check_eq("araddr_stable", o_araddr, prev_araddr);
            end
            if (b_arm) begin i_bvalid = 0; have_aw = 0; have_w = 0; b_cnt = 0; end
            if (r_arm) begin i_rvalid = 0; have_ar = 0; r_cnt = 0; end

            if (o_bready && !prev_bready) check_eq("bready_after_aw_w", 32'(have_aw && have_w), 1);
            if (o_rready && !prev_rready) check_eq("rready_after_ar", 32'(have_ar), 1);

            if (o_awvalid && !i_awready) begin
                if (aw_cnt >= aw_dly) begin i_awready = 1; aw_cap = o_awaddr; end
                else aw_cnt++;
            end
            if (o_wvalid && !i_wready) begin
                if (w_cnt >= w_dly) begin i_wready = 1; w_cap = o_wdata; ws_cap = o_wstrb; end
                else w_cnt++;
            end
            if (o_arvalid && !i_arready) begin
                if (ar_cnt >= ar_dly) begin i_arready = 1; ar_cap = o_araddr; end
                else ar_cnt++;
            end
            if (have_aw && have_w && !i_bvalid) begin
                if (b_cnt >= b_dly) begin
                    slv_mem[aw_cap[5:2]] = apply_strb(slv_mem[aw_cap[5:2]], w_cap, ws_cap);
                    i_bvalid = 1; i_bresp = b_resp_sel;
                end else b_cnt++;
            end
            if (have_ar && !i_rvalid) begin
                if (r_cnt >= r_dly) begin
                    i_rvalid = 1; i_rdata = slv_mem[ar_cap[5:2]]; i_rresp = r_resp_sel;
                end else r_cnt++;
            end

            aw_arm = i_awready && o_awvalid;
            w_arm  = i_wready && o_wvalid;
            ar_arm = i_arready && o_arvalid;
            b_arm  = i_bvalid && o_bready;
            r_arm  = i_rvalid && o_rready;
            prev_awvalid = o_awvalid; prev_awaddr = o_awaddr;
            prev_wvalid  = o_wvalid;  prev_wdata  = o_wdata; prev_wstrb = o_wstrb;
            prev_arvalid = o_arvalid; prev_araddr = o_araddr;
            prev_bready  = o_bready;  prev_rready = o_rready;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [16] = '{default: 32'h0};
    int          ref_err = 0;

    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold, input bit chk_lat);
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          n;
        if (wr) begin
            ref_mem[addr[5:2]] = apply_strb(ref_mem[addr[5:2]], data, strb);
            exp_rdata = 32'h0;
            exp_resp  = b_resp_sel;
        end else begin
            exp_rdata = ref_mem[addr[5:2]];
            exp_resp  = r_resp_sel;
        end
        if (exp_resp != 2'b00 && ref_err < 255) ref_err++;

        i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = addr;
        i_cmd_wdata = data; i_cmd_wstrb = strb;
        n = 0;
        while (!o_cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!o_cmd_ready) check_eq("cmd_ready_timeout", 32'(o_cmd_ready), 1);
        @(negedge clk);
        i_cmd_valid = 0;
        if (chk_lat) begin
            check_eq("valids_at_t1", 32'({o_awvalid, o_wvalid, o_arvalid}),
                     wr ? 32'h6 : 32'h1);
            check_eq("cmd_ready_busy", 32'(o_cmd_ready), 0);
        end
        n = 1;
        while (!o_rsp_valid && n < 200) begin @(negedge clk); n++; end
        check_eq("rsp_valid", 32'(o_rsp_valid), 1);
        if (chk_lat) check_eq("rsp_latency", 32'(n), 3);
        check_eq("rsp_write", 32'(o_rsp_write), 32'(wr));
        check_eq("rsp_rdata", o_rsp_rdata, exp_rdata);
        check_eq("rsp_resp", 32'(o_rsp_resp), 32'(exp_resp));
        check_eq("err_count", 32'(o_err_count), 32'(ref_err));

        // A competing command waits while the response is unconsumed.
        if (hold > 0) begin
            i_cmd_valid = 1; i_cmd_write = 0; i_cmd_addr = 32'h0000_0010;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_rsp_valid", 32'(o_rsp_valid), 1);
            check_eq("hold_rsp_rdata", o_rsp_rdata, exp_rdata);
            check_eq("hold_rsp_resp", 32'(o_rsp_resp), 32'(exp_resp));
            check_eq("hold_cmd_ready", 32'(o_cmd_ready), 0);
        end
        i_rsp_ready = 1;
        @(negedge clk);
        i_rsp_ready = 0;
        check_eq("rsp_valid_clear", 32'(o_rsp_valid), 0);
        check_eq("cmd_ready_idle", 32'(o_cmd_ready), 1);
        if (hold > 0) begin
            check_eq("pending_not_taken", 32'(o_arvalid), 0);
            i_cmd_valid = 0;
        end
    endtask

    task automatic set_zero_wait();
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        b_resp_sel = 2'b00; r_resp_sel = 2'b00;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 32'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready,
                           o_rsp_valid, o_rsp_write, o_rsp_resp}), 0);
        check_eq({tag, "_addr"}, o_awaddr | o_araddr, 0);
        check_eq({tag, "_data"}, o_wdata | o_rsp_rdata, 0);
        check_eq({tag, "_strb_err"}, 32'({o_wstrb, o_err_count}), 0);
    endtask

    initial begin
        #1 rst = 1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 0;
        @(negedge clk);
        check_eq("cmd_ready_after_reset", 32'(o_cmd_ready), 1);

        // Zero-wait write then write/read-back.
        set_zero_wait();
        do_cmd(1, 32'h0, 32'hDEAD_BEEF, 4'hF, 0, 1);
        do_cmd(1, 32'h4, 32'h1234_5678, 4'hF, 0, 1);
        do_cmd(0, 32'h4, 32'h0, 4'h0, 0, 1);
        do_cmd(0, 32'h0, 32'h0, 4'h0, 0, 1);

        // W accepted three cycles ahead of AW.
        w_dly = 0; aw_dly = 3;
        do_cmd(1, 32'hC, 32'hA5A5_1234, 4'hF, 0, 0);
        set_zero_wait();
        do_cmd(0, 32'hC, 32'h0, 4'h0, 0, 1);

        // Response held off for five cycles with a competing command pending.
        do_cmd(0, 32'h4, 32'h0, 4'h0, 5, 1);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            b_resp_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            r_resp_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            do_cmd(1'($urandom), {26'h0, 4'($urandom), 2'b00}, $urandom,
                   4'($urandom), $urandom_range(0, 2), 0);
        end

        // Asynchronous reset while AR is waiting for its ready.
        set_zero_wait();
        ar_dly = 10;
        i_cmd_valid = 1; i_cmd_write = 0; i_cmd_addr = 32'h8;
        @(negedge clk);
        i_cmd_valid = 0;
        @(negedge clk);
        check_eq("arvalid_before_reset", 32'(o_arvalid), 1);
        #2 rst = 1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        ref_err = 0;
        set_zero_wait();
        @(negedge clk);
        check_eq("cmd_ready_after_abort", 32'(o_cmd_ready), 1);
        check_eq("err_count_cleared", 32'(o_err_count), 0);

        // Error responses until the counter saturates.
        r_resp_sel = 2'b10;
        do_cmd(0, 32'h8, 32'h0, 4'h0, 0, 1);
        for (int t = 1; t < 300; t++) do_cmd(0, 32'h8, 32'h0, 4'h0, 0, 0);
        check_eq("err_count_saturated", 32'(o_err_count), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
